// File: rtl/ring_net_endpoint_adapter.sv
// Ring network endpoint: tags, injects and ejects terminal traffic.
// Option: RING_NET_ENDPOINT_SELF_BYPASS_EN routes self-addressed requests locally.
module ring_net_endpoint_adapter #(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_port_id       = 0,
  parameter int p_max_inflight  = 8,
  localparam int c_net_msg_nbits =
    p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_val,
  output logic                       req_rdy,
  input  logic [p_srcdest_nbits-1:0] req_dest,
  input  logic [p_payload_nbits-1:0] req_payload,
  output logic                       net_in_val,
  input  logic                       net_in_rdy,
  output logic [c_net_msg_nbits-1:0] net_in_msg,
  input  logic                       net_out_val,
  output logic                       net_out_rdy,
  input  logic [c_net_msg_nbits-1:0] net_out_msg,
  output logic                       resp_val,
  input  logic                       resp_rdy,
  output logic [p_srcdest_nbits-1:0] resp_src,
  output logic [p_opaque_nbits-1:0]  resp_opaque,
  output logic [p_payload_nbits-1:0] resp_payload,
  output logic [p_opaque_nbits:0]    inflight,
  output logic                       err
);

  localparam int P = p_payload_nbits;
  localparam int O = p_opaque_nbits;
  localparam int S = p_srcdest_nbits;
  localparam int M = c_net_msg_nbits;
  localparam int W = O + 1;
  localparam logic [S-1:0] ID = S'(p_port_id);

  logic [p_max_inflight-1:0] busy, busy_nxt;
  logic [W-1:0]              cnt_nxt;
  logic                      any_free;
  logic [O-1:0]              tag;
  logic                      hit, out_ok;
  logic                      req_fire, out_fire, resp_fire;
  logic                      inj_load, byp_fire, ej_free;
  logic                      inj_val;
  logic [M-1:0]              inj_msg;
  logic                      ej_val;
  logic [S-1:0]              ej_src;
  logic [O-1:0]              ej_opq;
  logic [P-1:0]              ej_pay;

  logic [S-1:0] out_dest, out_src;
  logic [O-1:0] out_opq;
  logic [P-1:0] out_pay;

  assign out_dest = net_out_msg[M-1 -: S];
  assign out_src  = net_out_msg[M-S-1 -: S];
  assign out_opq  = net_out_msg[P+O-1 -: O];
  assign out_pay  = net_out_msg[P-1:0];

  // Lowest free tag from the registered busy vector.
  always_comb begin
    any_free = 1'b0;
    tag      = '0;
    for (int i = p_max_inflight - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        any_free = 1'b1;
        tag      = O'(i);
      end
    end
  end

  // Ejected tag must be in range and currently busy.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < p_max_inflight; i++) begin
      if (busy[i] && out_opq == O'(i)) hit = 1'b1;
    end
  end

  assign out_ok      = (out_dest == ID) & hit;
  assign ej_free     = !ej_val | resp_rdy;
  assign net_out_rdy = reset & ej_free;
  assign net_in_val  = inj_val;
  assign net_in_msg  = inj_msg;
  assign resp_val    = ej_val;
  assign resp_src    = ej_src;
  assign resp_opaque = ej_opq;
  assign resp_payload = ej_pay;

`ifdef RING_NET_ENDPOINT_SELF_BYPASS_EN
  logic self_req;
  assign self_req = (req_dest == ID);
  assign req_rdy  = reset & any_free &
                    (self_req ? (ej_free & !net_out_val)
                              : (!inj_val | net_in_rdy));
  assign byp_fire = req_fire & self_req;
  assign inj_load = req_fire & !self_req;
`else
  assign req_rdy  = reset & any_free & (!inj_val | net_in_rdy);
  assign byp_fire = 1'b0;
  assign inj_load = req_fire;
`endif

  assign req_fire  = req_val & req_rdy;
  assign out_fire  = net_out_val & net_out_rdy;
  assign resp_fire = ej_val & resp_rdy;

  // Allocate and free update the busy vector independently.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < p_max_inflight; i++) begin
      if (req_fire && tag == O'(i)) busy_nxt[i] = 1'b1;
      if (resp_fire && ej_opq == O'(i)) busy_nxt[i] = 1'b0;
    end
    cnt_nxt = inflight + W'(req_fire) - W'(resp_fire);
  end

  // Inject/eject registers, tag state and sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= '0;
      inflight <= '0;
      err      <= 1'b0;
      inj_val  <= 1'b0;
      inj_msg  <= '0;
      ej_val   <= 1'b0;
      ej_src   <= '0;
      ej_opq   <= '0;
      ej_pay   <= '0;
    end else begin
      busy     <= busy_nxt;
      inflight <= cnt_nxt;
      if (inj_load) begin
        inj_val <= 1'b1;
        inj_msg <= {req_dest, ID, tag, req_payload};
      end else if (net_in_rdy) begin
        inj_val <= 1'b0;
      end
      if (out_fire && out_ok) begin
        ej_val <= 1'b1;
        ej_src <= out_src;
        ej_opq <= out_opq;
        ej_pay <= out_pay;
      end else if (byp_fire) begin
        ej_val <= 1'b1;
        ej_src <= ID;
        ej_opq <= tag;
        ej_pay <= req_payload;
      end else if (resp_fire) begin
        ej_val <= 1'b0;
      end
      if (out_fire && !out_ok) err <= 1'b1;
    end
  end

endmodule
